// File: rtl/tim_arb_sched.sv
// tim_arb_sched: round-robin arbiter in front of one shared down-counting timer.
//
// A requester raises req_valid_i[k] with a tick count on req_cnt_i[k]. While the timer
// is idle, one requester is granted per cycle (req_ready_o one-hot, combinational).
// The grant loads the count and the timer counts it down, one tick every pscr_i
// clk_i cycles. At expiry a one-cycle done_o pulse goes to the owner and the sticky
// irq_o is set. The owner can cancel with abort_i.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   pscr_i       tick period in clk_i cycles (0 and 1 both mean every cycle)
//   req_valid_i  per-requester timeout request
//   req_cnt_i    per-requester tick count, requester k at [k*CNT_WIDTH +: CNT_WIDTH]
//   req_ready_o  one-hot accept strobe (idle cycles only)
//   abort_i      per-requester cancel (only the current owner's bit matters)
//   irq_clr_i    clears irq_o
//   busy_o       timer owned (RUN or DONE)
//   gnt_id_o     current or last owner index
//   cnt_o        remaining ticks
//   done_o       one-cycle one-hot expiry pulse
//   irq_o        sticky expiry interrupt
module tim_arb_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned PSCR_WIDTH = 20
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [PSCR_WIDTH-1:0]        pscr_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] req_cnt_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ-1:0]           abort_i,
    input  logic                         irq_clr_i,
    output logic                         busy_o,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id_o,
    output logic [CNT_WIDTH-1:0]         cnt_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic                         irq_o
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [PSCR_WIDTH-1:0] r_pscr;
    logic [GW-1:0]         r_gnt_id;
    logic [GW-1:0]         r_last_gnt;
    logic [NUM_REQ-1:0]    r_done;
    logic                  r_irq;

    logic                  w_any;
    logic                  w_found;
    logic [GW-1:0]         w_cand;
    logic [GW-1:0]         w_gnt;
    logic [CNT_WIDTH-1:0]  w_load_cnt;
    logic                  w_tick;
    logic                  w_abort;

    // Round-robin search starting just after the last owner.
    always_comb begin
        w_any   = |req_valid_i;
        w_found = 1'b0;
        w_cand  = '0;
        w_gnt   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = GW'((32'(r_last_gnt) + i) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_comb begin
        w_load_cnt = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt == GW'(k)) begin
                w_load_cnt = req_cnt_i[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    // ">=" rather than "==" so that shrinking pscr_i mid-period ticks at once instead
    // of running the prescaler round the full register range.
    assign w_tick  = (pscr_i <= PSCR_WIDTH'(1)) || (r_pscr >= pscr_i - PSCR_WIDTH'(1));
    assign w_abort = abort_i[r_gnt_id];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_pscr     <= '0;
            r_gnt_id   <= '0;
            r_last_gnt <= GW'(NUM_REQ - 1);
            r_done     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_done <= '0;

            // Setting in DONE has priority over a coincident clear.
            if (r_state == StDone) begin
                r_irq <= 1'b1;
            end else if (irq_clr_i) begin
                r_irq <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_cnt      <= w_load_cnt;
                        r_gnt_id   <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_pscr     <= '0;
                        if (w_load_cnt == '0) begin
                            r_state <= StDone;
                            r_done  <= OneHot0 << w_gnt;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Abort wins over a coincident final tick.
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        r_pscr  <= '0;
                    end else if (w_tick) begin
                        r_pscr <= '0;
                        r_cnt  <= r_cnt - CNT_WIDTH'(1);
                        if (r_cnt == CNT_WIDTH'(1)) begin
                            r_state <= StDone;
                            r_done  <= OneHot0 << r_gnt_id;
                        end
                    end else begin
                        r_pscr <= r_pscr + PSCR_WIDTH'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = ((r_state == StIdle) && w_any) ? (OneHot0 << w_gnt) : '0;
    assign busy_o      = (r_state != StIdle);
    assign gnt_id_o    = r_gnt_id;
    assign cnt_o       = r_cnt;
    assign done_o      = r_done;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_tim_arb_sched.sv
// Testbench for tim_arb_sched: directed scenarios with fixed expectations, then
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_tim_arb_sched;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pscr;
    logic [N-1:0]  req_valid;
    logic [N*CW-1:0] req_cnt;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  abort;
    logic          irq_clr;
    logic          busy;
    logic [1:0]    gnt_id;
    logic [CW-1:0] cnt;
    logic [N-1:0]  done;
    logic          irq;

    always #5 clk = ~clk;

    tim_arb_sched #(
        .NUM_REQ    (N),
        .CNT_WIDTH  (CW),
        .PSCR_WIDTH (PW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pscr_i      (pscr),
        .req_valid_i (req_valid),
        .req_cnt_i   (req_cnt),
        .req_ready_o (req_ready),
        .abort_i     (abort),
        .irq_clr_i   (irq_clr),
        .busy_o      (busy),
        .gnt_id_o    (gnt_id),
        .cnt_o       (cnt),
        .done_o      (done),
        .irq_o       (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: mode 0 = free, 1 = counting, 2 = expiring.
    int m_mode  = 0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_left  = 0;
    int m_phase = 0;
    bit m_irq   = 1'b0;

    logic [N-1:0]  e_ready, e_done;
    logic          e_busy, e_irq;
    logic [1:0]    e_gnt;
    logic [CW-1:0] e_cnt;

    function automatic int rr_pick();
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (m_last + off) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_eval();
        int k;
        k       = rr_pick();
        e_busy  = (m_mode != 0);
        e_gnt   = 2'(m_owner);
        e_cnt   = CW'(m_left);
        e_irq   = m_irq;
        e_done  = (m_mode == 2) ? (4'(1) << m_owner) : '0;
        e_ready = (m_mode == 0 && k >= 0) ? (4'(1) << k) : '0;
    endtask

    task automatic model_update();
        int k;
        int period;
        if (rst) begin
            m_mode = 0; m_owner = 0; m_last = N - 1; m_left = 0; m_phase = 0; m_irq = 1'b0;
            return;
        end
        if (m_mode == 2) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
        case (m_mode)
            0: begin
                k = rr_pick();
                if (k >= 0) begin
                    m_owner = k;
                    m_last  = k;
                    m_left  = int'(req_cnt[k*CW +: CW]);
                    m_phase = 0;
                    m_mode  = (m_left == 0) ? 2 : 1;
                end
            end
            1: begin
                if (abort[m_owner]) begin
                    m_mode = 0; m_left = 0; m_phase = 0;
                end else begin
                    period = (pscr <= 1) ? 1 : int'(pscr);
                    if (m_phase + 1 >= period) begin
                        m_phase = 0;
                        m_left  = m_left - 1;
                        if (m_left == 0) m_mode = 2;
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // Inputs are driven #1 after posedge; outputs are sampled at negedge.
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_cnt(input int k, input int v);
        req_cnt[k*CW +: CW] = CW'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; abort = '0; irq_clr = 1'b0; pscr = '0; req_cnt = '0;
        advance();
        advance();
        rst = 1'b0;
        settle();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt got %0d want 0", gnt_id); end
        n_vec++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        n_vec++; if ({done, irq, req_ready} !== 9'b0) begin
            n_err++; $display("FAIL reset_done_irq_ready got %b want 0", {done, irq, req_ready});
        end
        advance();
    endtask

    task automatic test_single();
        pscr = PW'(4); set_cnt(2, 3); req_valid = 4'b0100;
        settle();
        n_vec++; if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready got %b want 0100", req_ready);
        end
        advance();
        req_valid = '0;
        for (int i = 0; i <= 12; i++) begin
            logic [N-1:0] xd;
            logic [CW-1:0] xc;
            settle();
            xd = (i == 12) ? 4'b0100 : 4'b0000;
            xc = (i < 12) ? CW'(3 - i / 4) : '0;
            n_vec++; if (done !== xd) begin
                n_err++; $display("FAIL single_done cyc %0d got %b want %b", i, done, xd);
            end
            n_vec++; if (cnt !== xc) begin
                n_err++; $display("FAIL single_cnt cyc %0d got %0d want %0d", i, cnt, xc);
            end
            if (i == 0) begin
                n_vec++; if ({busy, gnt_id} !== 3'b110) begin
                    n_err++; $display("FAIL single_busy_gnt got %b want 110", {busy, gnt_id});
                end
            end
            advance();
        end
        settle();
        n_vec++; if ({irq, busy} !== 2'b10) begin
            n_err++; $display("FAIL single_irq_set got %b want 10", {irq, busy});
        end
        advance();
        settle();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq_sticky got %0b want 1", irq); end
        irq_clr = 1'b1;
        advance();
        irq_clr = 1'b0;
        settle();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_clr got %0b want 0", irq); end
        advance();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        pscr = PW'(1);
        for (int k = 0; k < N; k++) set_cnt(k, 1);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            logic [N-1:0] oh;
            oh = 4'(1) << (g % N);
            settle();
            n_vec++; if (req_ready !== oh) begin
                n_err++; $display("FAIL rr_ready grant %0d got %b want %b", g, req_ready, oh);
            end
            advance();
            settle();
            n_vec++; if ({busy, gnt_id, req_ready} !== {1'b1, 2'(g % N), 4'b0000}) begin
                n_err++; $display("FAIL rr_run grant %0d got busy %0b gnt %0d ready %b want 1 %0d 0000",
                                  g, busy, gnt_id, req_ready, g % N);
            end
            advance();
            settle();
            n_vec++; if ({done, gnt_id} !== {oh, 2'(g % N)}) begin
                n_err++; $display("FAIL rr_done grant %0d got %b/%0d want %b/%0d", g, done, gnt_id, oh, g % N);
            end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_zero_count();
        req_valid = 4'b0010; set_cnt(1, 0);
        settle();
        n_vec++; if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL zero_ready got %b want 0010", req_ready);
        end
        advance();
        req_valid = '0;
        settle();
        n_vec++; if ({done, busy, cnt} !== {4'b0010, 1'b1, 32'd0}) begin
            n_err++; $display("FAIL zero_done got done %b busy %0b cnt %0d want 0010 1 0", done, busy, cnt);
        end
        advance();
        settle();
        n_vec++; if ({done, busy} !== 5'b0) begin
            n_err++; $display("FAIL zero_idle got %b want 00000", {done, busy});
        end
        advance();
    endtask

    task automatic test_abort();
        req_valid = 4'b1000; set_cnt(3, 5); pscr = PW'(8);
        settle();
        n_vec++; if (req_ready !== 4'b1000) begin
            n_err++; $display("FAIL abort_ready got %b want 1000", req_ready);
        end
        advance();
        req_valid = '0;
        abort = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if ({busy, gnt_id, cnt} !== {1'b1, 2'd3, 32'd5}) begin
                n_err++; $display("FAIL abort_other cyc %0d got busy %0b gnt %0d cnt %0d want 1 3 5",
                                  i, busy, gnt_id, cnt);
            end
            advance();
        end
        abort = 4'b1000;
        settle();
        advance();
        abort = '0;
        settle();
        n_vec++; if ({busy, cnt, done} !== '0) begin
            n_err++; $display("FAIL abort_idle got busy %0b cnt %0d done %b want 0 0 0000", busy, cnt, done);
        end
        advance();
        settle();
        n_vec++; if (done !== 4'b0) begin n_err++; $display("FAIL abort_nodone got %b want 0000", done); end
        advance();
    endtask

    task automatic test_collision();
        irq_clr = 1'b1;
        advance();
        irq_clr = 1'b0;
        req_valid = 4'b0001; set_cnt(0, 1); pscr = PW'(2);
        settle();
        n_vec++; if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL coll_ready got %b want 0001", req_ready);
        end
        advance();
        req_valid = '0;
        settle();
        advance();
        abort = 4'b0001;
        settle();
        n_vec++; if (cnt !== 32'd1) begin n_err++; $display("FAIL coll_cnt got %0d want 1", cnt); end
        advance();
        abort = '0;
        settle();
        n_vec++; if ({busy, done, cnt} !== '0) begin
            n_err++; $display("FAIL coll_abort got busy %0b done %b cnt %0d want 0 0000 0", busy, done, cnt);
        end
        advance();
        settle();
        n_vec++; if ({irq, done} !== 5'b0) begin
            n_err++; $display("FAIL coll_noirq got %b want 00000", {irq, done});
        end
        advance();
        req_valid = 4'b0010; set_cnt(1, 0);
        settle();
        advance();
        req_valid = '0;
        irq_clr = 1'b1;
        settle();
        n_vec++; if (done !== 4'b0010) begin n_err++; $display("FAIL coll_done got %b want 0010", done); end
        advance();
        irq_clr = 1'b0;
        settle();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL coll_setwins got %0b want 1", irq); end
        advance();
    endtask

    task automatic test_reset_mid_run();
        req_valid = 4'b0100; set_cnt(2, 7); pscr = PW'(5);
        settle();
        advance();
        req_valid = '0;
        settle();
        n_vec++; if ({busy, cnt} !== {1'b1, 32'd7}) begin
            n_err++; $display("FAIL rstrun_cnt got busy %0b cnt %0d want 1 7", busy, cnt);
        end
        advance();
        settle();
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        req_valid = 4'b1111;
        settle();
        n_vec++; if ({busy, gnt_id, cnt, done, irq} !== '0) begin
            n_err++; $display("FAIL rstrun_outs got busy %0b gnt %0d cnt %0d done %b irq %0b want all 0",
                              busy, gnt_id, cnt, done, irq);
        end
        n_vec++; if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL rstrun_first got %b want 0001", req_ready);
        end
        advance();
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) pscr = PW'($urandom_range(0, 4));
            req_valid = 4'($urandom) & 4'($urandom);
            for (int k = 0; k < N; k++) set_cnt(k, int'($urandom_range(0, 5)));
            abort   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            irq_clr = ($urandom_range(0, 5) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            settle();
            n_vec++;
            if ({req_ready, busy, gnt_id, cnt, done, irq} !== {e_ready, e_busy, e_gnt, e_cnt, e_done, e_irq}) begin
                n_err++;
                $display("FAIL random cyc %0d got rdy %b busy %0b gnt %0d cnt %0d done %b irq %0b want rdy %b busy %0b gnt %0d cnt %0d done %b irq %0b",
                         c, req_ready, busy, gnt_id, cnt, done, irq,
                         e_ready, e_busy, e_gnt, e_cnt, e_done, e_irq);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pscr = '0; req_valid = '0; req_cnt = '0; abort = '0; irq_clr = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_abort();
        test_collision();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tim_arb_sched.md
TIM_ARB_SCHED -- requirements
Module: tim_arb_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, timeout count width.
REQ-003 SHALL have parameter PSCR_WIDTH, default 20, prescaler width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port pscr_i  input  PSCR_WIDTH  tick period in clk_i cycles.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ  per-requester timeout request.
REQ-008 SHALL have port req_cnt_i  input  NUM_REQ*CNT_WIDTH  per-requester tick count, requester k at bits [k*CNT_WIDTH +: CNT_WIDTH].
REQ-009 SHALL have port req_ready_o  output  NUM_REQ  one-hot accept strobe.
REQ-010 SHALL have port abort_i  input  NUM_REQ  per-requester cancel.
REQ-011 SHALL have port irq_clr_i  input  1  clears irq_o.
REQ-012 SHALL have port busy_o  output  1  shared timer owned.
REQ-013 SHALL have port gnt_id_o  output  $clog2(NUM_REQ)  current or last owner index.
REQ-014 SHALL have port cnt_o  output  CNT_WIDTH  remaining ticks.
REQ-015 SHALL have port done_o  output  NUM_REQ  one-cycle expiry pulse, one-hot.
REQ-016 SHALL have port irq_o  output  1  sticky expiry interrupt.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE with any req_valid_i set SHALL grant exactly one requester k in the same cycle, round-robin starting at (last_gnt+1) mod NUM_REQ, asserting req_ready_o[k] combinationally for that cycle only.
REQ-019 On grant SHALL load cnt_o <= req_cnt_i[k], gnt_id_o <= k, last_gnt <= k, clear prescaler, go RUN; if the loaded count is 0, SHALL go DONE instead.
REQ-020 req_ready_o SHALL be all-zero in RUN and DONE; requests are held, not dropped.
REQ-021 In RUN, the prescaler SHALL count 0..pscr_i-1 and produce a tick when prescaler == pscr_i-1; pscr_i of 0 or 1 SHALL tick every cycle.
REQ-022 On each tick cnt_o SHALL decrement by 1; the tick taking cnt_o from 1 to 0 SHALL move FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle: done_o[gnt_id_o]=1, set irq_o, then IDLE; no grant is issued in DONE.
REQ-024 abort_i[gnt_id_o] in RUN SHALL return to IDLE next cycle with cnt_o cleared to 0, no done_o, no irq; abort_i of non-owners SHALL be ignored.
REQ-025 Abort and final tick in the same cycle: abort SHALL win.
REQ-026 abort_i is not examined in IDLE; req_valid_i[k] and abort_i[k] together in IDLE SHALL still grant.
REQ-027 irq_clr_i SHALL clear irq_o next cycle; set in DONE and irq_clr_i same cycle: set SHALL win.
REQ-028 busy_o SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-029 pscr_i changes mid-RUN SHALL take effect on the next prescaler compare; no glitch tick beyond wrap (prescaler >= pscr_i-1 treated as compare match).
REQ-030 Minimum request-to-request throughput: grant, RUN, DONE, IDLE => next grant no earlier than 1 cycle after DONE.

Reset
REQ-031 rst_i SHALL force, on the next clk_i edge regardless of state: FSM IDLE, cnt_o 0, prescaler 0, gnt_id_o 0, last_gnt NUM_REQ-1 (requester 0 first priority), irq_o 0, done_o 0, busy_o 0.
REQ-032 Reset mid-RUN SHALL discard the active timeout without a done_o pulse.

Verification
REQ-033 Single request: pscr_i=4, req_valid_i[2]=1, cnt=3 -> req_ready_o=0100 one cycle, done_o[2] pulse 12 cycles after RUN entry, irq_o=1 until irq_clr_i.
REQ-034 Round-robin: all four valid continuously, cnt=1, pscr_i=1 -> grant order 0,1,2,3,0; each done_o one-hot matching gnt_id_o.
REQ-035 Zero count: req_valid_i[1]=1, cnt=0 -> IDLE->DONE, done_o[1] next cycle, cnt_o=0.
REQ-036 Abort: owner 3 in RUN cnt_o=5, abort_i[3]=1 -> IDLE next cycle, cnt_o=0, no done_o; abort_i[0] while owner 3 -> ignored.
REQ-037 Collision: abort_i coincident with final tick -> no done_o, no irq; irq_clr_i coincident with DONE -> irq_o=1.
REQ-038 Reset mid-RUN cnt_o=7 -> all outputs reset values next cycle; next grant goes to requester 0 if valid.
